// File: rtl/bit_count_fsm.sv
`default_nettype none
// ============================================================================
// Module      : bit_count_fsm
// Description : Serial bit-counting engine. Counts the ones (mode=0) or the
//               zeros (mode=1) in a DATA_W-bit operand. The operand is
//               right-shifted one bit per clock while the LSB is accumulated.
//               start/done form a level handshake.
//
// Parameters  : DATA_W  - operand width, legal range 2..64
//               CNT_W   - derived result width, $clog2(DATA_W+1)
//
// Ports       : clk       in   system clock, rising edge
//               areset_n  in   asynchronous active-low reset
//               start     in   level request, sampled in IDLE and DONE only
//               mode      in   0 = count ones, 1 = count zeros (load only)
//               data_in   in   operand (sampled on the load edge only)
//               result    out  binary count, valid while done=1
//               done      out  high in DONE state
//               busy      out  high in SHIFT state
//
// Build option: BIT_COUNT_EARLY_EXIT_EN
//               When defined, SHIFT also finishes as soon as the remaining
//               shifted operand is all zeros. The result is the same; only
//               the latency shrinks.
//
// Revision    : 1.0 - initial release
// ============================================================================
module bit_count_fsm #(
    parameter int DATA_W = 8
) (
    input  logic                              clk,
    input  logic                              areset_n,
    input  logic                              start,
    input  logic                              mode,
    input  logic [DATA_W-1:0]                 data_in,
    output logic [$clog2(DATA_W+1)-1:0]       result,
    output logic                              done,
    output logic                              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // Index value seen on the last fixed-latency SHIFT edge
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [CNT_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_result;
    logic                r_done;
    logic                r_busy;

    logic [DATA_W-1:0]   w_a_shr;
    logic [CNT_W-1:0]    w_lsb_ext;
    logic                w_last;

    assign w_a_shr   = r_a >> 1;
    assign w_lsb_ext = {{(CNT_W-1){1'b0}}, r_a[0]};

`ifdef BIT_COUNT_EARLY_EXIT_EN
    // Once nothing is left above the current LSB, the remaining shifts would
    // only add zeros, so the count is already final after this edge.
    assign w_last = (r_idx == c_last_idx) || (w_a_shr == '0);
`else
    assign w_last = (r_idx == c_last_idx);
`endif

    // Single state machine; done/busy are registered alongside the state so
    // they come straight from flops and can never be high together.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // Counting zeros is counting ones of the inverse
                        r_a      <= mode ? ~data_in : data_in;
                        r_result <= '0;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_state  <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // Maximum count is DATA_W < 2^CNT_W: no overflow possible
                    r_result <= r_result + w_lsb_ext;
                    r_a      <= w_a_shr;
                    r_idx    <= r_idx + 1'b1;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Held start does not retrigger; a fresh request must
                    // pass through IDLE first.
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = r_busy;

endmodule
`default_nettype wire
